output_port_stage: RTL and testbench
====================================

Name: output_port_stage

Overview:
- Per-output-port stage directly downstream of the crossbar: registers the flit leaving one crossbar output onto the inter-router link.
- Tracks downstream buffer credits per VC.
- Runs a per-VC ownership state machine that tells the switch/VC allocators which downstream VCs can take a flit and which are free for a new packet.
- One instance per output port; PORT_NUM instances per router.

Parameters:
- VC_NUM, 2, number of virtual channels per link (from noc_params)
- BUFFER_SIZE, 8, downstream input buffer depth per VC, in flits; initial and maximum credit count
- VC_SIZE, $clog2(VC_NUM), width of a VC index
- CNT_W, $clog2(BUFFER_SIZE+1), credit counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- valid_i  in  1  crossbar output carries a granted flit this cycle
- data_i  in  $bits(flit_t)  flit from crossbar data_o[port]; fields vc_id, flit_label used
- credit_valid_i  in  1  downstream returned one credit this cycle
- credit_vc_i  in  VC_SIZE  VC of returned credit
- valid_o  out  1  link flit valid
- data_o  out  $bits(flit_t)  link flit
- has_credit_o  out  VC_NUM  bit v = credit count of VC v nonzero (to switch allocator)
- is_allocatable_o  out  VC_NUM  bit v = VC v idle and fully drained (to VC allocator)
- credit_err_o  out  1  sticky: credit underflow or overflow detected
- protocol_err_o  out  1  sticky: flit_label sequence violation

Behaviour:
- Reset: sampled on posedge clk with rst==0.
  - valid_o=0, data_o=0, all counters=BUFFER_SIZE, all VC states IDLE.
  - has_credit_o all 1, is_allocatable_o all 1, both error flags 0.
  - Reset mid-packet discards all state; no flit is emitted in the cycle after reset.
- Datapath, 1-cycle latency:
  - valid_i/data_i sampled at edge N appear on valid_o/data_o after edge N.
  - data_o holds its last value when valid_o=0.
  - The flit is always forwarded, even when an error flag sets.
- Credit counter cnt[v], CNT_W bits:
  - Accept (valid_i && data_i.vc_id==v): decrement.
  - Return (credit_valid_i && credit_vc_i==v): increment.
  - Both in the same cycle on the same VC: counter unchanged, no error.
  - Accept with cnt==0 and no same-cycle return: no decrement (stays 0), credit_err_o<=1.
  - Return with cnt==BUFFER_SIZE and no same-cycle accept: saturate, credit_err_o<=1.
  - Accept and return on different VCs in one cycle: both updates apply independently.
- has_credit_o[v] = (cnt[v]!=0), decoded from registered counters; no combinational path from inputs.
- Per-VC FSM, states IDLE / ACTIVE / DRAIN, label from the accepted flit:
  - IDLE: HEAD -> ACTIVE; HEADTAIL -> DRAIN; BODY or TAIL -> protocol_err_o<=1, stay IDLE.
  - ACTIVE: BODY -> stay; TAIL -> DRAIN; HEAD or HEADTAIL -> protocol_err_o<=1, stay ACTIVE.
  - DRAIN: go to IDLE when the next-cycle counter value == BUFFER_SIZE, evaluated every cycle including the cycle the tail is accepted.
  - DRAIN: any accepted flit -> protocol_err_o<=1, counter still updated, stay DRAIN.
- is_allocatable_o[v] = (state[v]==IDLE), registered-state decode.
- Error flags are sticky until reset.
- Simultaneous events: credit return and flit accept on different VCs are fully independent.

Test Plan:
- Reset release -> valid_o=0, has_credit_o=2'b11, is_allocatable_o=2'b11, cnt=8 per VC, error flags 0.
- HEAD, BODY, TAIL on VC0 in cycles 1-3, no returns:
  - valid_o high cycles 2-4, data_o equal to inputs delayed by one cycle.
  - cnt0=5; VC0 ACTIVE then DRAIN; is_allocatable_o[0]=0.
  - Three VC0 credit returns -> VC0 IDLE on the edge cnt0 reaches 8.
- 8 HEAD/BODY flits on VC1 -> has_credit_o[1]=0 after the 8th. A 9th flit -> still forwarded, cnt1 stays 0, credit_err_o=1.
- Same-cycle accept and return on VC0 at cnt0=3 -> cnt0 stays 3, no error. Accept VC0 plus return VC1 -> cnt0-1, cnt1+1.
- HEADTAIL on VC0 with a same-cycle VC0 return at cnt0=8 -> cnt0 stays 8, FSM goes straight to IDLE, is_allocatable_o[0] remains 1.
- Protocol and reset cases:
  - BODY on an IDLE VC -> protocol_err_o=1, flit forwarded.
  - Credit return at cnt=8 -> credit_err_o=1.
  - rst=0 mid-packet -> all state back to reset values next edge, flags cleared.

Source files
------------

// File: rtl/output_port_stage.sv
// Purpose : one router output port. Registers the crossbar flit onto the link,
//           keeps a per-VC count of downstream credits and runs a per-VC ownership FSM.
// Latency : 1 cycle from valid_i/data_i to valid_o/data_o.
// Backpressure: none on the flit path. Upstream allocators throttle through
//           has_credit_o and is_allocatable_o. Misuse only raises the sticky error flags.
// Ports   : clk, rst (sync, active-low); valid_i/data_i = flit from crossbar;
//           credit_valid_i/credit_vc_i = credit returned by downstream;
//           valid_o/data_o = link flit; has_credit_o/is_allocatable_o = per-VC
//           status to the SA/VA; credit_err_o/protocol_err_o = sticky errors.

package noc_pkg;
  localparam int VC_NUM  = 2;
  localparam int VC_SIZE = $clog2(VC_NUM);

  typedef logic [VC_SIZE-1:0] vc_id_t;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t flit_label;
    vc_id_t      vc_id;
    logic [15:0] payload;
  } flit_t;
endpackage

module output_port_stage
  import noc_pkg::*;
#(
  parameter int VC_NUM      = noc_pkg::VC_NUM,
  parameter int BUFFER_SIZE = 8,
  parameter int VC_SIZE     = $clog2(VC_NUM),
  parameter int CNT_W       = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  flit_t               data_i,
  input  logic                credit_valid_i,
  input  logic [VC_SIZE-1:0]  credit_vc_i,
  output logic                valid_o,
  output flit_t               data_o,
  output logic [VC_NUM-1:0]   has_credit_o,
  output logic [VC_NUM-1:0]   is_allocatable_o,
  output logic                credit_err_o,
  output logic                protocol_err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } vc_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUFFER_SIZE);

  logic [CNT_W-1:0] cnt      [VC_NUM];
  logic [CNT_W-1:0] cnt_nxt  [VC_NUM];
  vc_state_t        state    [VC_NUM];
  vc_state_t        state_nxt[VC_NUM];
  logic [VC_NUM-1:0] acc;
  logic [VC_NUM-1:0] ret;
  logic              cerr_set;
  logic              perr_set;

  // Per-VC decode of this cycle's flit accept and credit return.
  always_comb begin
    acc = '0;
    ret = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      acc[v] = valid_i && (data_i.vc_id == vc_id_t'(v));
      ret[v] = credit_valid_i && (credit_vc_i == VC_SIZE'(v));
    end
  end

  // Counter and ownership next-state logic.
  always_comb begin
    cerr_set = 1'b0;
    perr_set = 1'b0;
    for (int v = 0; v < VC_NUM; v++) begin
      cnt_nxt[v]   = cnt[v];
      state_nxt[v] = state[v];

      // Accept and return on the same VC cancel out.
      if (acc[v] && !ret[v]) begin
        if (cnt[v] == '0) cerr_set = 1'b1;
        else              cnt_nxt[v] = cnt[v] - CNT_W'(1);
      end else if (ret[v] && !acc[v]) begin
        if (cnt[v] == CNT_MAX) cerr_set = 1'b1;
        else                   cnt_nxt[v] = cnt[v] + CNT_W'(1);
      end

      case (state[v])
        IDLE: begin
          if (acc[v]) begin
            case (data_i.flit_label)
              HEAD:     state_nxt[v] = ACTIVE;
              HEADTAIL: state_nxt[v] = DRAIN;
              default:  perr_set = 1'b1;
            endcase
          end
        end
        ACTIVE: begin
          if (acc[v]) begin
            case (data_i.flit_label)
              BODY:    state_nxt[v] = ACTIVE;
              TAIL:    state_nxt[v] = DRAIN;
              default: perr_set = 1'b1;
            endcase
          end
        end
        DRAIN: begin
          if (acc[v]) perr_set = 1'b1;
        end
        default: state_nxt[v] = IDLE;
      endcase

      // Release as soon as the downstream buffer will be empty. Checking the
      // next-state value covers the tail cycle itself, so a packet whose last
      // credit comes back alongside its tail never lingers in DRAIN.
      if (state_nxt[v] == DRAIN && cnt_nxt[v] == CNT_MAX) state_nxt[v] = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_o        <= 1'b0;
      data_o         <= '0;
      credit_err_o   <= 1'b0;
      protocol_err_o <= 1'b0;
      for (int v = 0; v < VC_NUM; v++) begin
        cnt[v]   <= CNT_MAX;
        state[v] <= IDLE;
      end
    end else begin
      valid_o <= valid_i;
      if (valid_i) data_o <= data_i;
      if (cerr_set) credit_err_o   <= 1'b1;
      if (perr_set) protocol_err_o <= 1'b1;
      for (int v = 0; v < VC_NUM; v++) begin
        cnt[v]   <= cnt_nxt[v];
        state[v] <= state_nxt[v];
      end
    end
  end

  // Status decoded from registered state only.
  always_comb begin
    has_credit_o     = '0;
    is_allocatable_o = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      has_credit_o[v]     = (cnt[v] != '0);
      is_allocatable_o[v] = (state[v] == IDLE);
    end
  end

endmodule

// File: tb/tb_output_port_stage.sv
module tb_output_port_stage;
  import noc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  flit_t       data_i = '0;
  logic        credit_valid_i = 1'b0;
  logic [0:0]  credit_vc_i = '0;
  logic        valid_o;
  flit_t       data_o;
  logic [1:0]  has_credit_o;
  logic [1:0]  is_allocatable_o;
  logic        credit_err_o;
  logic        protocol_err_o;

  int total = 0;
  int bad   = 0;

  output_port_stage dut (
    .clk              (clk),
    .rst              (rst),
    .valid_i          (valid_i),
    .data_i           (data_i),
    .credit_valid_i   (credit_valid_i),
    .credit_vc_i      (credit_vc_i),
    .valid_o          (valid_o),
    .data_o           (data_o),
    .has_credit_o     (has_credit_o),
    .is_allocatable_o (is_allocatable_o),
    .credit_err_o     (credit_err_o),
    .protocol_err_o   (protocol_err_o)
  );

  always #5 clk = ~clk;

  function automatic flit_t mk(input flit_label_t l, input logic vc, input logic [15:0] p);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = vc;
    f.payload    = p;
    return f;
  endfunction

  // Advance one edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input flit_t f, input logic cv, input logic cvc);
    valid_i        = v;
    data_i         = f;
    credit_valid_i = cv;
    credit_vc_i    = cvc;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    total++; if (data_o !== flit_t'(0)) begin bad++; $display("FAIL reset_data: got %h want 0", data_o); end
    total++; if (has_credit_o !== 2'b11) begin bad++; $display("FAIL reset_has_credit: got %b want 11", has_credit_o); end
    total++; if (is_allocatable_o !== 2'b11) begin bad++; $display("FAIL reset_alloc: got %b want 11", is_allocatable_o); end
    total++; if (dut.cnt[0] !== 4'd8 || dut.cnt[1] !== 4'd8) begin bad++; $display("FAIL reset_cnt: got %0d/%0d want 8/8", dut.cnt[0], dut.cnt[1]); end
    total++; if ({credit_err_o, protocol_err_o} !== 2'b00) begin bad++; $display("FAIL reset_errs: got %b want 00", {credit_err_o, protocol_err_o}); end
  endtask

  task automatic test_packet();
    flit_t f [3];
    apply_reset();
    f[0] = mk(HEAD, 1'b0, 16'h1001);
    f[1] = mk(BODY, 1'b0, 16'h1002);
    f[2] = mk(TAIL, 1'b0, 16'h1003);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, f[i], 1'b0, 1'b0);
      tick();
      total++; if (valid_o !== 1'b1 || data_o !== f[i]) begin bad++; $display("FAIL pkt_fwd%0d: got %b/%h want 1/%h", i, valid_o, data_o, f[i]); end
      total++; if (dut.cnt[0] !== 4'(7 - i)) begin bad++; $display("FAIL pkt_cnt%0d: got %0d want %0d", i, dut.cnt[0], 7 - i); end
      total++; if (is_allocatable_o[0] !== 1'b0) begin bad++; $display("FAIL pkt_alloc%0d: got %b want 0", i, is_allocatable_o[0]); end
    end
    total++; if (dut.state[0] !== 2'd2) begin bad++; $display("FAIL pkt_drain: got %0d want 2", dut.state[0]); end
    // Credits come back one per cycle; VC0 frees on the edge it reaches 8.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
      total++; if (valid_o !== 1'b0 || data_o !== f[2]) begin bad++; $display("FAIL pkt_hold%0d: got %b/%h want 0/%h", i, valid_o, data_o, f[2]); end
      total++; if (dut.cnt[0] !== 4'(6 + i)) begin bad++; $display("FAIL ret_cnt%0d: got %0d want %0d", i, dut.cnt[0], 6 + i); end
      total++; if (is_allocatable_o[0] !== (i == 2)) begin bad++; $display("FAIL ret_alloc%0d: got %b want %b", i, is_allocatable_o[0], i == 2); end
    end
    total++; if ({credit_err_o, protocol_err_o} !== 2'b00) begin bad++; $display("FAIL pkt_errs: got %b want 00", {credit_err_o, protocol_err_o}); end
    idle();
  endtask

  task automatic test_credit_exhaust();
    flit_t f;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, mk(i == 0 ? HEAD : BODY, 1'b1, 16'(16'h2000 + i)), 1'b0, 1'b0);
      tick();
    end
    total++; if (has_credit_o !== 2'b01) begin bad++; $display("FAIL exh_has_credit: got %b want 01", has_credit_o); end
    total++; if (dut.cnt[1] !== 4'd0) begin bad++; $display("FAIL exh_cnt: got %0d want 0", dut.cnt[1]); end
    total++; if (credit_err_o !== 1'b0) begin bad++; $display("FAIL exh_err_early: got %b want 0", credit_err_o); end
    f = mk(BODY, 1'b1, 16'h2009);
    drive(1'b1, f, 1'b0, 1'b0);
    tick();
    total++; if (valid_o !== 1'b1 || data_o !== f) begin bad++; $display("FAIL exh_fwd: got %b/%h want 1/%h", valid_o, data_o, f); end
    total++; if (dut.cnt[1] !== 4'd0) begin bad++; $display("FAIL exh_cnt_stay: got %0d want 0", dut.cnt[1]); end
    total++; if (credit_err_o !== 1'b1 || protocol_err_o !== 1'b0) begin bad++; $display("FAIL exh_errs: got %b%b want 10", credit_err_o, protocol_err_o); end
    idle();
    tick();
    total++; if (credit_err_o !== 1'b1) begin bad++; $display("FAIL exh_sticky: got %b want 1", credit_err_o); end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    drive(1'b1, mk(HEAD, 1'b1, 16'h3100), 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, mk(i == 0 ? HEAD : BODY, 1'b0, 16'(16'h3000 + i)), 1'b0, 1'b0);
      tick();
    end
    total++; if (dut.cnt[0] !== 4'd3 || dut.cnt[1] !== 4'd7) begin bad++; $display("FAIL same_setup: got %0d/%0d want 3/7", dut.cnt[0], dut.cnt[1]); end
    drive(1'b1, mk(BODY, 1'b0, 16'h3005), 1'b1, 1'b0);
    tick();
    total++; if (dut.cnt[0] !== 4'd3) begin bad++; $display("FAIL same_vc_cnt: got %0d want 3", dut.cnt[0]); end
    total++; if (credit_err_o !== 1'b0) begin bad++; $display("FAIL same_vc_err: got %b want 0", credit_err_o); end
    drive(1'b1, mk(BODY, 1'b0, 16'h3006), 1'b1, 1'b1);
    tick();
    total++; if (dut.cnt[0] !== 4'd2 || dut.cnt[1] !== 4'd8) begin bad++; $display("FAIL diff_vc_cnt: got %0d/%0d want 2/8", dut.cnt[0], dut.cnt[1]); end
    total++; if ({credit_err_o, protocol_err_o} !== 2'b00) begin bad++; $display("FAIL diff_vc_errs: got %b want 00", {credit_err_o, protocol_err_o}); end
    idle();
  endtask

  task automatic test_headtail_bypass();
    flit_t f;
    apply_reset();
    f = mk(HEADTAIL, 1'b0, 16'h4444);
    drive(1'b1, f, 1'b1, 1'b0);
    tick();
    total++; if (valid_o !== 1'b1 || data_o !== f) begin bad++; $display("FAIL ht_fwd: got %b/%h want 1/%h", valid_o, data_o, f); end
    total++; if (dut.cnt[0] !== 4'd8) begin bad++; $display("FAIL ht_cnt: got %0d want 8", dut.cnt[0]); end
    total++; if (is_allocatable_o !== 2'b11) begin bad++; $display("FAIL ht_alloc: got %b want 11", is_allocatable_o); end
    total++; if ({credit_err_o, protocol_err_o} !== 2'b00) begin bad++; $display("FAIL ht_errs: got %b want 00", {credit_err_o, protocol_err_o}); end
    idle();
  endtask

  task automatic test_protocol();
    flit_t f;
    apply_reset();
    f = mk(BODY, 1'b1, 16'h5555);
    drive(1'b1, f, 1'b0, 1'b0);
    tick();
    total++; if (valid_o !== 1'b1 || data_o !== f) begin bad++; $display("FAIL prot_fwd: got %b/%h want 1/%h", valid_o, data_o, f); end
    total++; if (protocol_err_o !== 1'b1 || credit_err_o !== 1'b0) begin bad++; $display("FAIL prot_err: got p=%b c=%b want p=1 c=0", protocol_err_o, credit_err_o); end
    total++; if (is_allocatable_o[1] !== 1'b1 || dut.cnt[1] !== 4'd7) begin bad++; $display("FAIL prot_state: got alloc=%b cnt=%0d want 1/7", is_allocatable_o[1], dut.cnt[1]); end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    total++; if (credit_err_o !== 1'b1 || dut.cnt[0] !== 4'd8) begin bad++; $display("FAIL ovf: got err=%b cnt=%0d want 1/8", credit_err_o, dut.cnt[0]); end
    // Flit into a draining VC: flagged, still counted, state held.
    drive(1'b1, mk(HEAD, 1'b1, 16'h5600), 1'b0, 1'b0);
    tick();
    drive(1'b1, mk(TAIL, 1'b1, 16'h5601), 1'b0, 1'b0);
    tick();
    drive(1'b1, mk(HEAD, 1'b1, 16'h5602), 1'b0, 1'b0);
    tick();
    total++; if (dut.cnt[1] !== 4'd4 || dut.state[1] !== 2'd2) begin bad++; $display("FAIL drain_acc: got cnt=%0d st=%0d want 4/2", dut.cnt[1], dut.state[1]); end
    idle();
  endtask

  task automatic test_midpacket_reset();
    // Flags are still set from the previous scenario.
    drive(1'b1, mk(HEAD, 1'b0, 16'h6000), 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b1, mk(BODY, 1'b0, 16'h6001), 1'b0, 1'b0);
    tick();
    total++; if (valid_o !== 1'b0 || data_o !== flit_t'(0)) begin bad++; $display("FAIL mrst_out: got %b/%h want 0/0", valid_o, data_o); end
    total++; if (dut.cnt[0] !== 4'd8 || dut.cnt[1] !== 4'd8) begin bad++; $display("FAIL mrst_cnt: got %0d/%0d want 8/8", dut.cnt[0], dut.cnt[1]); end
    total++; if (is_allocatable_o !== 2'b11 || has_credit_o !== 2'b11) begin bad++; $display("FAIL mrst_status: got %b/%b want 11/11", is_allocatable_o, has_credit_o); end
    total++; if ({credit_err_o, protocol_err_o} !== 2'b00) begin bad++; $display("FAIL mrst_errs: got %b want 00", {credit_err_o, protocol_err_o}); end
    rst = 1'b1;
    idle();
    tick();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL mrst_after: got %b want 0", valid_o); end
  endtask

  initial begin
    test_reset();
    test_packet();
    test_credit_exhaust();
    test_same_cycle();
    test_headtail_bypass();
    test_protocol();
    test_midpacket_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Every scenario is a fixed number of cycles; this is only a safety net.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
